// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller: shadow EX/MEM destination tracking, RAW forward selects,
// load-use bubbles, mispredict flushes and syscall halt. Optional counters behind HAZARD_STATS_EN.
module hazard_fwd_ctrl #(
    parameter int REG_AW          = 5,
    parameter int LU_STALL_CYCLES = 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [REG_AW-1:0] id_r1,
    input  logic [REG_AW-1:0] id_r2,
    input  logic              id_r1_used,
    input  logic              id_r2_used,
    input  logic              id_r1_lo,
    input  logic              id_r2_lo,
    input  logic [REG_AW-1:0] id_rw,
    input  logic              id_we,
    input  logic              id_ld,
    input  logic              id_we_lo,
    input  logic              mispredict,
    input  logic              halt_req,
    input  logic              go,
    output logic              run,
    output logic              stall_front,
    output logic              bubble,
    output logic              clear_u,
    output logic [5:0]        redirection,
    output logic              halted,
    output logic [1:0]        dbg_state
`ifdef HAZARD_STATS_EN
    ,
    output logic [15:0]       stat_lu_cnt,
    output logic [15:0]       stat_flush_cnt
`endif
);

    // Handshake-free block: every output is a level valid in the cycle it is driven;
    // the ID/EX register and muxes sample them on the next rising clk edge.
    typedef enum logic [1:0] {
        S_RUN      = 2'd0,
        S_LU_STALL = 2'd1,
        S_HALT     = 2'd2
    } state_t;

    localparam logic [2:0] LU_LOAD = 3'(LU_STALL_CYCLES - 1);

    state_t            r_state;
    logic [2:0]        r_cnt;
    logic [REG_AW-1:0] r_ex_rw;
    logic              r_ex_we;
    logic              r_ex_ld;
    logic              r_ex_we_lo;
    logic [REG_AW-1:0] r_mem_rw;
    logic              r_mem_we;
    logic              r_mem_we_lo;

    logic       w_r1_ex;
    logic       w_r2_ex;
    logic       w_r1_mem;
    logic       w_r2_mem;
    logic       w_lo_pending;
    logic       w_lu;
    logic [5:0] w_redir;

    // Register 0 is hardwired, so it never needs a forwarded value.
    assign w_r1_ex  = id_r1_used && !id_r1_lo && r_ex_we  && (r_ex_rw  == id_r1) && (id_r1 != '0);
    assign w_r2_ex  = id_r2_used && !id_r2_lo && r_ex_we  && (r_ex_rw  == id_r2) && (id_r2 != '0);
    assign w_r1_mem = id_r1_used && !id_r1_lo && r_mem_we && (r_mem_rw == id_r1) && (id_r1 != '0);
    assign w_r2_mem = id_r2_used && !id_r2_lo && r_mem_we && (r_mem_rw == id_r2) && (id_r2 != '0);
    assign w_lo_pending = r_ex_we_lo || r_mem_we_lo;
    assign w_lu = r_ex_ld && (w_r1_ex || w_r2_ex);

    assign w_redir = {id_r2_lo && w_lo_pending, id_r1_lo && w_lo_pending,
                      w_r2_mem && !w_r2_ex, w_r1_mem && !w_r1_ex,
                      w_r2_ex, w_r1_ex};

    assign dbg_state = r_state;

    always_comb begin
        run         = 1'b1;
        stall_front = 1'b0;
        bubble      = 1'b0;
        clear_u     = 1'b0;
        halted      = 1'b0;
        redirection = '0;
        case (r_state)
            S_RUN: begin
                if (mispredict) begin
                    clear_u = 1'b1;
                end else if (!halt_req && w_lu) begin
                    bubble      = 1'b1;
                    stall_front = 1'b1;
                end
            end
            S_LU_STALL: begin
                if (mispredict) begin
                    clear_u = 1'b1;
                end else if (r_cnt != 3'd0) begin
                    bubble      = 1'b1;
                    stall_front = 1'b1;
                end
            end
            S_HALT: begin
                run    = 1'b0;
                halted = 1'b1;
            end
            default: ;
        endcase
        if (run && !bubble && !clear_u) begin
            redirection = w_redir;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
            r_cnt   <= 3'd0;
        end else begin
            case (r_state)
                S_RUN: begin
                    if (mispredict) begin
                        r_state <= S_RUN;
                    end else if (halt_req) begin
                        r_state <= S_HALT;
                    end else if (w_lu) begin
                        r_cnt <= LU_LOAD;
                        if (LU_LOAD != 3'd0) begin
                            r_state <= S_LU_STALL;
                        end
                    end
                end
                S_LU_STALL: begin
                    if (mispredict || r_cnt <= 3'd1) begin
                        r_cnt   <= 3'd0;
                        r_state <= S_RUN;
                    end else begin
                        r_cnt <= r_cnt - 3'd1;
                    end
                end
                S_HALT: begin
                    if (go) begin
                        r_state <= S_RUN;
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

    // Shadow destination pipe; frozen whenever the core is not running.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ex_rw     <= '0;
            r_ex_we     <= 1'b0;
            r_ex_ld     <= 1'b0;
            r_ex_we_lo  <= 1'b0;
            r_mem_rw    <= '0;
            r_mem_we    <= 1'b0;
            r_mem_we_lo <= 1'b0;
        end else if (run) begin
            r_mem_rw    <= r_ex_rw;
            r_mem_we    <= r_ex_we;
            r_mem_we_lo <= r_ex_we_lo;
            if (bubble || clear_u) begin
                r_ex_rw    <= '0;
                r_ex_we    <= 1'b0;
                r_ex_ld    <= 1'b0;
                r_ex_we_lo <= 1'b0;
            end else begin
                r_ex_rw    <= id_rw;
                r_ex_we    <= id_we;
                r_ex_ld    <= id_ld;
                r_ex_we_lo <= id_we_lo;
            end
        end
    end

`ifdef HAZARD_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_lu_cnt    <= 16'd0;
            stat_flush_cnt <= 16'd0;
        end else begin
            if (bubble && stat_lu_cnt != 16'hFFFF) begin
                stat_lu_cnt <= stat_lu_cnt + 16'd1;
            end
            if (clear_u && stat_flush_cnt != 16'hFFFF) begin
                stat_flush_cnt <= stat_flush_cnt + 16'd1;
            end
        end
    end
`endif

endmodule
